// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - word-addressed memory target with fixed-latency request/response handshake
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   readM       read request strobe (level)
//   writeM      write request strobe (level)
//   address     word address
//   data        shared bus; driven here only while inputReady is high
//   inputReady  one-cycle pulse, read data valid on data
//   ackOutput   one-cycle pulse, write committed
//   addr_error  out-of-range flag, pulses with the response
//
// Optional feature: define MEM_BOUNDS_CHECK_EN to flag and suppress accesses
// whose address is >= DEPTH; otherwise the address wraps modulo DEPTH.

module memory_responder #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 inputReady,
  output logic                 ackOutput,
  output logic                 addr_error
);

  localparam int DEPTH = 2**ADDR_BITS;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, RELEASE} state_t;

  state_t               state, state_d;
  logic [3:0]           cnt, cnt_d;
  logic                 req_read, req_read_d;
  logic [ADDR_BITS-1:0] req_idx, req_idx_d;
  logic [WORD_SIZE-1:0] req_data, req_data_d;
  logic                 req_oor, req_oor_d;
  logic [WORD_SIZE-1:0] rd_data_q, rd_data_d;
  logic                 ready_q, ready_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic                 mem_we;
  logic                 capture_oor;

  logic [WORD_SIZE-1:0] mem [DEPTH];

`ifdef MEM_BOUNDS_CHECK_EN
  assign capture_oor = |address[WORD_SIZE-1:ADDR_BITS];
`else
  // Upper address bits are deliberately ignored so accesses alias modulo DEPTH.
  wire unused_addr_hi = |address[WORD_SIZE-1:ADDR_BITS];
  assign capture_oor = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_read  <= 1'b0;
      req_idx   <= '0;
      req_data  <= '0;
      req_oor   <= 1'b0;
      rd_data_q <= '0;
      ready_q   <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      req_read  <= req_read_d;
      req_idx   <= req_idx_d;
      req_data  <= req_data_d;
      req_oor   <= req_oor_d;
      rd_data_q <= rd_data_d;
      ready_q   <= ready_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  // The array has no reset; a request aborted by reset never reaches the
  // commit point because the async reset pulls the FSM out of WAIT.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[req_idx] <= req_data;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    req_read_d = req_read;
    req_idx_d  = req_idx;
    req_data_d = req_data;
    req_oor_d  = req_oor;
    rd_data_d  = rd_data_q;
    ready_d    = 1'b0;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        if (readM || writeM) begin
          // A read wins when both strobes are seen together.
          req_read_d = readM;
          req_idx_d  = address[ADDR_BITS-1:0];
          req_data_d = data;
          req_oor_d  = capture_oor;
          cnt_d      = 4'(LATENCY - 1);
          state_d    = WAIT;
        end
      end
      WAIT: begin
        // The response registers load on the edge that enters RESP, so the
        // pulse is visible in the cycle after edge N+LATENCY.
        if (cnt == 4'd0) begin
          state_d = RESP;
          err_d   = req_oor;
          if (req_read) begin
            ready_d   = 1'b1;
            rd_data_d = req_oor ? {WORD_SIZE{1'b1}} : mem[req_idx];
          end else begin
            ack_d  = 1'b1;
            mem_we = !req_oor;
          end
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      RESP: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        // Wait for both strobes to drop so a held strobe is served only once.
        if (!readM && !writeM) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign data       = ready_q ? rd_data_q : {WORD_SIZE{1'bz}};
  assign inputReady = ready_q;
  assign ackOutput  = ack_q;
  assign addr_error = err_q;

endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - self-checking bench for memory_responder at LATENCY 2, 1 and 15

module tb_memory_responder;

`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [2:0]  rd_s;
  logic [2:0]  wr_s;
  logic [15:0] addr_s [3];
  logic [15:0] drv [3];
  logic [2:0]  drv_en;
  wire  [15:0] bus0, bus1, bus2;
  wire  [2:0]  rdy, ack, aerr;

  int errors = 0;
  int checks = 0;

  logic [15:0] model_mem [3][256];
  bit          model_vld [3][256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus0 = drv_en[0] ? drv[0] : 16'bz;
  assign bus1 = drv_en[1] ? drv[1] : 16'bz;
  assign bus2 = drv_en[2] ? drv[2] : 16'bz;

  memory_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(2)) u_l2 (
    .clk(clk), .reset_n(rst_n), .readM(rd_s[0]), .writeM(wr_s[0]), .address(addr_s[0]),
    .data(bus0), .inputReady(rdy[0]), .ackOutput(ack[0]), .addr_error(aerr[0]));
  memory_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(1)) u_l1 (
    .clk(clk), .reset_n(rst_n), .readM(rd_s[1]), .writeM(wr_s[1]), .address(addr_s[1]),
    .data(bus1), .inputReady(rdy[1]), .ackOutput(ack[1]), .addr_error(aerr[1]));
  memory_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(15)) u_l15 (
    .clk(clk), .reset_n(rst_n), .readM(rd_s[2]), .writeM(wr_s[2]), .address(addr_s[2]),
    .data(bus2), .inputReady(rdy[2]), .ackOutput(ack[2]), .addr_error(aerr[2]));

  function automatic int lat_of(input int k);
    case (k)
      0: return 2;
      1: return 1;
      default: return 15;
    endcase
  endfunction

  function automatic logic [15:0] bus_val(input int k);
    case (k)
      0: return bus0;
      1: return bus1;
      default: return bus2;
    endcase
  endfunction

  // Reference model: plain array indexed by address modulo 256, with
  // out-of-range accesses suppressed when bounds checking is built in.
  function automatic bit oor(input logic [15:0] a);
    return BOUNDS && (a >= 16'd256);
  endfunction

  function automatic void model_write(input int k, input logic [15:0] a, input logic [15:0] d);
    logic [7:0] i;
    i = a[7:0];
    if (!oor(a)) begin
      model_mem[k][i] = d;
      model_vld[k][i] = 1'b1;
    end
  endfunction

  function automatic logic [15:0] model_read(input int k, input logic [15:0] a);
    logic [7:0] i;
    i = a[7:0];
    return oor(a) ? 16'hFFFF : model_mem[k][i];
  endfunction

  function automatic bit model_known(input int k, input logic [15:0] a);
    logic [7:0] i;
    i = a[7:0];
    return oor(a) || model_vld[k][i];
  endfunction

  // One request: strobes held for the capture edge only, then watch for the
  // response pulse and confirm it is gone one cycle later.
  task automatic access(input int k, input bit rd, input bit wr, input logic [15:0] a,
                        input logic [15:0] wd, output bit found, output int cyc,
                        output logic [15:0] rdata, output bit got_rdy, output bit got_ack,
                        output bit got_err, output bit clean);
    found = 0; cyc = 0; rdata = '0; got_rdy = 0; got_ack = 0; got_err = 0; clean = 0;
    @(negedge clk);
    rd_s[k] = rd; wr_s[k] = wr; addr_s[k] = a; drv[k] = wd; drv_en[k] = wr;
    @(posedge clk);
    @(negedge clk);
    rd_s[k] = 1'b0; wr_s[k] = 1'b0; drv_en[k] = 1'b0;
    for (int c = 1; c <= 40 && !found; c++) begin
      @(posedge clk); #1;
      if (rdy[k] || ack[k]) begin
        found = 1; cyc = c; got_rdy = rdy[k]; got_ack = ack[k]; got_err = aerr[k];
        rdata = bus_val(k);
      end
    end
    if (found) begin
      @(posedge clk); #1;
      clean = !rdy[k] && !ack[k] && !aerr[k];
    end
    @(posedge clk);
  endtask

  task automatic test_reset;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({rdy[k], ack[k], aerr[k]} !== 3'b000) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got %b want 000", k, {rdy[k], ack[k], aerr[k]});
      end
    end
  endtask

  task automatic test_write_read;
    bit f, r, a, e, cl; int cyc; logic [15:0] d;
    access(0, 0, 1, 16'h0010, 16'hBEEF, f, cyc, d, r, a, e, cl);
    model_write(0, 16'h0010, 16'hBEEF);
    checks++;
    if (!f || cyc != 2 || !a || r || !cl) begin
      errors++;
      $display("FAIL write_ack: found=%0d cyc=%0d ack=%0d rdy=%0d clean=%0d want 1 2 1 0 1", f, cyc, a, r, cl);
    end
    access(0, 1, 0, 16'h0010, 16'h0000, f, cyc, d, r, a, e, cl);
    checks++;
    if (!f || cyc != 2 || !r || a || !cl) begin
      errors++;
      $display("FAIL read_rdy: found=%0d cyc=%0d rdy=%0d ack=%0d clean=%0d want 1 2 1 0 1", f, cyc, r, a, cl);
    end
    checks++;
    if (d !== model_read(0, 16'h0010)) begin
      errors++;
      $display("FAIL read_data: got %h want %h", d, model_read(0, 16'h0010));
    end
  endtask

  task automatic test_hold;
    bit f, r, a, e, cl; int cyc, pulses; logic [15:0] d, v;
    v = 16'(($urandom & 32'hFFFF) | 32'h1);
    access(0, 0, 1, 16'h0003, v, f, cyc, d, r, a, e, cl);
    model_write(0, 16'h0003, v);
    @(negedge clk);
    rd_s[0] = 1'b1; addr_s[0] = 16'h0003;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rdy[0]) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL hold_single_pulse: got %0d pulses want 1", pulses);
    end
    @(negedge clk); rd_s[0] = 1'b0;
    @(negedge clk); rd_s[0] = 1'b1;
    f = 0; cyc = 0; d = '0;
    for (int c = 1; c <= 10 && !f; c++) begin
      @(posedge clk); #1;
      if (rdy[0]) begin f = 1; cyc = c; d = bus0; end
    end
    @(negedge clk); rd_s[0] = 1'b0;
    repeat (2) @(posedge clk);
    checks++;
    if (!f || cyc != 3 || d !== model_read(0, 16'h0003)) begin
      errors++;
      $display("FAIL hold_rearm: found=%0d cyc=%0d data=%h want 1 3 %h", f, cyc, d, model_read(0, 16'h0003));
    end
  endtask

  task automatic test_reset_abort;
    bit f, r, a, e, cl; int cyc; logic [15:0] d; bit saw_ack;
    access(0, 0, 1, 16'h0005, 16'h0000, f, cyc, d, r, a, e, cl);
    model_write(0, 16'h0005, 16'h0000);
    @(negedge clk);
    wr_s[0] = 1'b1; addr_s[0] = 16'h0005; drv[0] = 16'h1234; drv_en[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wr_s[0] = 1'b0; drv_en[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rdy, ack, aerr} !== 9'b0) begin
      errors++;
      $display("FAIL abort_outputs: got %b want 0", {rdy, ack, aerr});
    end
    @(negedge clk); rst_n = 1'b1;
    saw_ack = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack[0]) saw_ack = 1;
    end
    checks++;
    if (saw_ack) begin
      errors++;
      $display("FAIL abort_no_ack: got ack=1 want 0");
    end
    access(0, 1, 0, 16'h0005, 16'h0000, f, cyc, d, r, a, e, cl);
    checks++;
    if (!f || d !== 16'h0000) begin
      errors++;
      $display("FAIL abort_not_committed: found=%0d data=%h want 1 0000", f, d);
    end
    // Reset asserted while the read response is on the bus drops it at once.
    @(negedge clk);
    rd_s[0] = 1'b1; addr_s[0] = 16'h0005;
    @(posedge clk);
    @(negedge clk); rd_s[0] = 1'b0;
    f = 0;
    for (int c = 1; c <= 5 && !f; c++) begin
      @(posedge clk); #1;
      if (rdy[0]) f = 1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (!f || rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_resp: seen=%0d rdy_after=%b want 1 0", f, rdy[0]);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_both_strobes;
    bit f, r, a, e, cl; int cyc; logic [15:0] d;
    access(0, 0, 1, 16'h0007, 16'h00AA, f, cyc, d, r, a, e, cl);
    model_write(0, 16'h0007, 16'h00AA);
    access(0, 1, 1, 16'h0007, 16'h5555, f, cyc, d, r, a, e, cl);
    checks++;
    if (!f || !r || a || d !== 16'h00AA) begin
      errors++;
      $display("FAIL both_strobes_read: rdy=%0d ack=%0d data=%h want 1 0 00aa", r, a, d);
    end
    access(0, 1, 0, 16'h0007, 16'h0000, f, cyc, d, r, a, e, cl);
    checks++;
    if (d !== 16'h00AA) begin
      errors++;
      $display("FAIL both_strobes_unchanged: got %h want 00aa", d);
    end
  endtask

  task automatic test_bounds;
    bit f, r, a, e, cl; int cyc; logic [15:0] d;
    access(0, 0, 1, 16'h0005, 16'h1111, f, cyc, d, r, a, e, cl);
    model_write(0, 16'h0005, 16'h1111);
    access(0, 0, 1, 16'h0105, 16'h2222, f, cyc, d, r, a, e, cl);
    model_write(0, 16'h0105, 16'h2222);
    checks++;
    if (!f || !a || cyc != 2 || e != oor(16'h0105)) begin
      errors++;
      $display("FAIL bounds_write: found=%0d ack=%0d cyc=%0d err=%0d want 1 1 2 %0d", f, a, cyc, e, oor(16'h0105));
    end
    access(0, 1, 0, 16'h0105, 16'h0000, f, cyc, d, r, a, e, cl);
    checks++;
    if (!f || !r || d !== model_read(0, 16'h0105) || e != oor(16'h0105) || !cl) begin
      errors++;
      $display("FAIL bounds_read: data=%h err=%0d clean=%0d want %h %0d 1", d, e, cl, model_read(0, 16'h0105), oor(16'h0105));
    end
    access(0, 1, 0, 16'h0005, 16'h0000, f, cyc, d, r, a, e, cl);
    checks++;
    if (d !== model_read(0, 16'h0005) || e) begin
      errors++;
      $display("FAIL bounds_alias: data=%h err=%0d want %h 0", d, e, model_read(0, 16'h0005));
    end
  endtask

  task automatic test_latency_sweep;
    bit f, r, a, e, cl; int cyc; logic [15:0] d, v, ad;
    for (int k = 1; k < 3; k++) begin
      v = 16'($urandom);
      ad = 16'($urandom_range(0, 255));
      access(k, 0, 1, ad, v, f, cyc, d, r, a, e, cl);
      model_write(k, ad, v);
      checks++;
      if (!f || cyc != lat_of(k) || !a) begin
        errors++;
        $display("FAIL sweep_write[%0d]: found=%0d cyc=%0d want 1 %0d", k, f, cyc, lat_of(k));
      end
      access(k, 1, 0, ad, 16'h0000, f, cyc, d, r, a, e, cl);
      checks++;
      if (!f || cyc != lat_of(k) || d !== model_read(k, ad) || !cl) begin
        errors++;
        $display("FAIL sweep_read[%0d]: found=%0d cyc=%0d data=%h clean=%0d want 1 %0d %h 1", k, f, cyc, d, cl, lat_of(k), model_read(k, ad));
      end
    end
  endtask

  task automatic test_back_to_back;
    bit f, r, a, e, cl; int cyc, k, op; logic [15:0] d, v, ad;
    for (int i = 0; i < 24; i++) begin
      k  = int'($urandom_range(0, 2));
      op = int'($urandom_range(0, 2));
      ad = {($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00, 8'($urandom_range(0, 15))};
      v  = 16'($urandom);
      access(k, op != 1, op != 0, ad, v, f, cyc, d, r, a, e, cl);
      checks++;
      if (!f || cyc != lat_of(k) || r != (op != 1) || a != (op == 1) || e != oor(ad) || !cl) begin
        errors++;
        $display("FAIL b2b_handshake[%0d]: inst=%0d op=%0d found=%0d cyc=%0d rdy=%0d ack=%0d err=%0d clean=%0d",
                 i, k, op, f, cyc, r, a, e, cl);
      end
      if (op == 1) begin
        model_write(k, ad, v);
      end else if (model_known(k, ad)) begin
        checks++;
        if (d !== model_read(k, ad)) begin
          errors++;
          $display("FAIL b2b_data[%0d]: inst=%0d addr=%h got %h want %h", i, k, ad, d, model_read(k, ad));
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rd_s = '0; wr_s = '0; drv_en = '0;
    for (int k = 0; k < 3; k++) begin
      addr_s[k] = '0;
      drv[k] = '0;
      for (int i = 0; i < 256; i++) begin
        model_mem[k][i] = '0;
        model_vld[k][i] = 1'b0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    test_write_read();
    test_hold();
    test_reset_abort();
    test_both_strobes();
    test_bounds();
    test_latency_sweep();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
